// File: rtl/oclib_pkg.sv
// oclib_pkg: shared CSR bus request/response types and widths used by oclib
// register blocks.
package oclib_pkg;

    localparam int CsrDataWidth    = 32;
    localparam int CsrIndexWidth   = 6;
    localparam int CsrLatencyWidth = 4;

    typedef struct packed {
        logic [CsrDataWidth-1:0] address;
        logic                    write;
        logic                    read;
        logic [CsrDataWidth-1:0] wdata;
    } csr_32_s;

    typedef struct packed {
        logic [CsrDataWidth-1:0] rdata;
        logic                    ready;
        logic                    error;
    } csr_32_fb_s;

endpackage

// File: rtl/oclib_csr_array.sv
// oclib_csr_array: bank of NumCsr 32-bit registers, each either writable config
// or read-only status, behind one request/response port with fixed response latency.
module oclib_csr_array
    import oclib_pkg::*;
#(
    parameter type                  CsrType         = oclib_pkg::csr_32_s,
    parameter type                  CsrFbType       = oclib_pkg::csr_32_fb_s,
    parameter int                   NumCsr          = 8,
    parameter logic [NumCsr-1:0]    CsrRwMask       = '1,
    parameter logic [NumCsr*32-1:0] CsrInit         = '0,
    parameter int                   ResponseLatency = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 csrSelect,
    input  CsrType               csr,
    output CsrFbType             csrFb,
    output logic [NumCsr*32-1:0] csrConfig,
    input  logic [NumCsr*32-1:0] csrStatus
);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StRespond,
        StRelease
    } state_e;

    state_e                     state_q, state_d;
    logic [CsrLatencyWidth-1:0] count_q, count_d;
    logic [CsrIndexWidth-1:0]   index_q, index_d;
    logic [31:0]                wdata_q, wdata_d;
    logic                       is_write_q, is_write_d;
    logic                       is_error_q, is_error_d;
    logic [31:0]                rdata_q, rdata_d;
    logic                       ready_q, ready_d;
    logic                       error_q, error_d;
    logic [31:0]                regs_q [NumCsr];
    logic [31:0]                regs_d [NumCsr];

    logic                       req_active;
    logic [CsrIndexWidth-1:0]   req_index;
    logic                       req_hit;
    logic                       req_writable;
    logic                       req_error;
    logic [31:0]                read_value;
    logic                       unused_addr;

    assign req_active  = csr.read || csr.write;
    assign req_index   = csr.address[7:2];
    assign unused_addr = ^{csr.address[31:8]};

    // Decode the live request against the register map for error classification.
    always_comb begin
        req_hit      = 1'b0;
        req_writable = 1'b0;
        for (int unsigned i = 0; i < NumCsr; i++) begin
            if (req_index == CsrIndexWidth'(i)) begin
                req_hit      = 1'b1;
                req_writable = CsrRwMask[i];
            end
        end
        req_error = (csr.address[1:0] != 2'b00) || !req_hit ||
                    (csr.read && csr.write) || (csr.write && !req_writable);
    end

    always_comb begin
        read_value = '0;
        for (int unsigned i = 0; i < NumCsr; i++) begin
            if (index_q == CsrIndexWidth'(i)) begin
                read_value = CsrRwMask[i] ? regs_q[i] : csrStatus[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        index_d    = index_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        is_error_d = is_error_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        regs_d     = regs_q;

        case (state_q)
            StIdle: begin
                if (csrSelect && req_active) begin
                    index_d    = req_index;
                    wdata_d    = csr.wdata;
                    is_write_d = csr.write;
                    is_error_d = req_error;
                    count_d    = CsrLatencyWidth'(ResponseLatency);
                    state_d    = StWait;
                end
            end
            StWait: begin
                // A dropped request abandons the transaction before any side effect.
                if (!req_active) begin
                    state_d = StIdle;
                end else if (count_q == '0) begin
                    state_d = StRespond;
                    if (is_error_q) begin
                        error_d = 1'b1;
                        rdata_d = '0;
                    end else begin
                        ready_d = 1'b1;
                        rdata_d = is_write_q ? '0 : read_value;
                        if (is_write_q) begin
                            for (int unsigned i = 0; i < NumCsr; i++) begin
                                if (index_q == CsrIndexWidth'(i) && CsrRwMask[i]) begin
                                    regs_d[i] = wdata_q;
                                end
                            end
                        end
                    end
                end else begin
                    count_d = count_q - 1'b1;
                end
            end
            StRespond: begin
                state_d = StRelease;
            end
            StRelease: begin
                if (!req_active) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            count_q    <= '0;
            index_q    <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
            is_error_q <= 1'b0;
            rdata_q    <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
            for (int unsigned i = 0; i < NumCsr; i++) begin
                regs_q[i] <= CsrRwMask[i] ? CsrInit[32*i +: 32] : '0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            index_q    <= index_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            is_error_q <= is_error_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            error_q    <= error_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        csrFb       = '0;
        csrFb.rdata = rdata_q;
        csrFb.ready = ready_q;
        csrFb.error = error_q;
    end

    for (genvar g = 0; g < NumCsr; g++) begin : g_config
        assign csrConfig[32*g +: 32] = CsrRwMask[g] ? regs_q[g] : '0;
    end

endmodule

// File: tb/tb_oclib_csr_array.sv
// Randomized bench for oclib_csr_array: three configurations checked against a
// register-map reference model (latency, error rules, write visibility, reset).
module tb_oclib_csr_array;
    import oclib_pkg::*;

    localparam int NDut = 3;
    localparam logic [255:0] Init0 = 256'h88888888_77777777_66666666_55555555_44444444_33333333_22222222_11111111;
    localparam logic [255:0] Init1 = 256'hA7A7A7A7_A6A6A6A6_A5A5A5A5_A4A4A4A4_A3A3A3A3_A2A2A2A2_A1A1A1A1_A0A0A0A0;
    localparam logic [191:0] Init2 = 192'hB5B5B5B5_B4B4B4B4_B3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;

    logic         clk = 1'b0;
    logic         rst;
    logic         sel0, sel1, sel2;
    csr_32_s      req0, req1, req2;
    csr_32_fb_s   fb0, fb1, fb2;
    logic [255:0] cfg0, cfg1;
    logic [191:0] cfg2;
    logic [255:0] status;

    int unsigned  n_checks = 0;
    int unsigned  n_pass   = 0;
    logic [31:0]  mregs [NDut][8];
    int unsigned  num_csr [NDut] = '{8, 8, 6};
    int unsigned  lat     [NDut] = '{0, 3, 5};
    logic [7:0]   rw_mask [NDut] = '{8'hFE, 8'hA5, 8'h2B};

    always #5 clk = ~clk;

    oclib_csr_array #(.NumCsr(8), .CsrRwMask(8'hFE), .CsrInit(Init0), .ResponseLatency(0)) dut0 (
        .clock(clk), .reset(rst), .csrSelect(sel0), .csr(req0), .csrFb(fb0),
        .csrConfig(cfg0), .csrStatus(status));
    oclib_csr_array #(.NumCsr(8), .CsrRwMask(8'hA5), .CsrInit(Init1), .ResponseLatency(3)) dut1 (
        .clock(clk), .reset(rst), .csrSelect(sel1), .csr(req1), .csrFb(fb1),
        .csrConfig(cfg1), .csrStatus(status));
    oclib_csr_array #(.NumCsr(6), .CsrRwMask(6'h2B), .CsrInit(Init2), .ResponseLatency(5)) dut2 (
        .clock(clk), .reset(rst), .csrSelect(sel2), .csr(req2), .csrFb(fb2),
        .csrConfig(cfg2), .csrStatus(status[191:0]));

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic csr_32_fb_s get_fb(input int k);
        case (k)
            0:       return fb0;
            1:       return fb1;
            default: return fb2;
        endcase
    endfunction

    function automatic logic [255:0] get_cfg(input int k);
        case (k)
            0:       return cfg0;
            1:       return cfg1;
            default: return {64'h0, cfg2};
        endcase
    endfunction

    function automatic logic [31:0] init_word(input int k, input int unsigned i);
        case (k)
            0:       return Init0[32*i +: 32];
            1:       return Init1[32*i +: 32];
            default: return Init2[32*i +: 32];
        endcase
    endfunction

    function automatic logic [255:0] model_cfg(input int k);
        logic [255:0] v = '0;
        for (int unsigned i = 0; i < num_csr[k]; i++)
            if (rw_mask[k][i]) v[32*i +: 32] = mregs[k][i];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDut; k++)
            for (int unsigned i = 0; i < 8; i++)
                mregs[k][i] = (i < num_csr[k] && rw_mask[k][i]) ? init_word(k, i) : 32'h0;
    endtask

    task automatic drive(input int k, input logic s, input csr_32_s r);
        case (k)
            0:       begin sel0 = s; req0 = r; end
            1:       begin sel1 = s; req1 = r; end
            default: begin sel2 = s; req2 = r; end
        endcase
    endtask

    // Starts at a negedge with the DUT idle; holds the request for `hold` cycles.
    task automatic run_txn(input int k, input logic [31:0] addr, input logic [31:0] wd,
                           input logic rd, input logic wr, input int unsigned hold);
        csr_32_s     r;
        csr_32_fb_s  f;
        int unsigned idx;
        bit          err;
        int unsigned pulses;
        logic [31:0] exp_rd;
        idx = int'(addr[7:2]);
        err = (addr[1:0] != 2'b00) || (idx >= num_csr[k]) || (rd && wr);
        if (!err && wr && !rw_mask[k][idx]) err = 1'b1;
        exp_rd = '0;
        if (!err && rd) exp_rd = rw_mask[k][idx] ? mregs[k][idx] : status[32*idx +: 32];
        r.address = addr; r.write = wr; r.read = rd; r.wdata = wd;
        drive(k, 1'b1, r);
        pulses = 0;
        for (int unsigned n = 1; n <= hold; n++) begin
            @(negedge clk);
            f = get_fb(k);
            if (f.ready || f.error) pulses++;
            if (n == lat[k] + 2) begin
                if (!err && wr) mregs[k][idx] = wd;
                check("ready", f.ready, !err);
                check("error", f.error, err);
                if (err || rd) check("rdata", f.rdata, exp_rd);
                check("config", get_cfg(k), model_cfg(k));
            end
        end
        check("one_pulse", pulses, 1);
        drive(k, 1'b1, '0);
        @(negedge clk);
    endtask

    task automatic count_pulses(input int k, input int unsigned cycles, output int unsigned pulses);
        csr_32_fb_s f;
        pulses = 0;
        for (int unsigned n = 0; n < cycles; n++) begin
            @(negedge clk);
            f = get_fb(k);
            if (f.ready || f.error) pulses++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        csr_32_s     r;
        int unsigned pulses;
        int          k;
        logic [31:0] addr;
        int unsigned op;

        rst = 1'b0;
        status = '0;
        for (int i = 0; i < NDut; i++) drive(i, 1'b1, '0);
        model_reset();
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < NDut; i++) begin
            check("reset_fb", get_fb(i), '0);
            check("reset_cfg", get_cfg(i), model_cfg(i));
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_txn(0, 32'h4, 32'h12345678, 1'b0, 1'b1, 4);
        check("cfg_word1", cfg0[63:32], 32'h12345678);
        status[31:0] = 32'hCAFEF00D;
        run_txn(0, 32'h0, 32'h0, 1'b1, 1'b0, 4);
        run_txn(0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 4);
        run_txn(0, 32'h22, 32'h55AA55AA, 1'b0, 1'b1, 4);
        run_txn(0, 32'h40, 32'h55AA55AA, 1'b1, 1'b0, 4);
        run_txn(0, 32'hFFFF_FF0C, 32'h0BADCAFE, 1'b0, 1'b1, 4);
        run_txn(1, 32'h8, 32'h0, 1'b1, 1'b1, 8);
        run_txn(1, 32'h8, 32'h0, 1'b1, 1'b0, 20);

        // Read dropped during the latency window: no response, no side effect.
        r = '0; r.address = 32'h4; r.read = 1'b1;
        drive(2, 1'b1, r);
        @(negedge clk);
        @(negedge clk);
        drive(2, 1'b1, '0);
        count_pulses(2, lat[2] + 4, pulses);
        check("abort_pulses", pulses, 0);
        check("abort_cfg", get_cfg(2), model_cfg(2));
        run_txn(2, 32'h4, 32'h13579BDF, 1'b0, 1'b1, 9);

        // Requests are ignored while csrSelect is low.
        r = '0; r.address = 32'h8; r.write = 1'b1; r.wdata = 32'hFEEDFACE;
        drive(0, 1'b0, r);
        count_pulses(0, 6, pulses);
        check("deselect_pulses", pulses, 0);
        check("deselect_cfg", get_cfg(0), model_cfg(0));
        drive(0, 1'b1, '0);
        @(negedge clk);

        // Reset in the middle of a write's wait window.
        run_txn(1, 32'h0, 32'h11111111, 1'b0, 1'b1, 6);
        r = '0; r.address = 32'h0; r.write = 1'b1; r.wdata = 32'hFFFFFFFF;
        drive(1, 1'b1, r);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        drive(1, 1'b1, '0);
        model_reset();
        #1;
        check("midrst_cfg", get_cfg(1), model_cfg(1));
        check("midrst_fb", get_fb(1), '0);
        @(negedge clk);
        rst = 1'b0;
        count_pulses(1, 10, pulses);
        check("midrst_pulses", pulses, 0);
        for (int i = 0; i < NDut; i++) check("postrst_cfg", get_cfg(i), model_cfg(i));

        // Randomized traffic across all three configurations.
        for (int t = 0; t < 180; t++) begin
            k = int'($urandom_range(0, NDut - 1));
            for (int w = 0; w < 8; w++) status[32*w +: 32] = $urandom;
            addr = $urandom;
            addr[7:2] = 6'($urandom_range(0, 9));
            if ($urandom_range(0, 7) != 0) addr[1:0] = 2'b00;
            op = $urandom_range(0, 9);
            run_txn(k, addr, $urandom, (op < 5) || (op == 9), op >= 5,
                    lat[k] + 3 + $urandom_range(0, 5));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
